// File: rtl/dsp_defs.sv
// Shared constants for the envelope detector: FSM encodings, pipeline depth and
// the alpha-max-beta-min shift amounts (|z| ~ max + min>>2 + min>>3).
package dsp_defs;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_FLUSH  = 3'd2;
  localparam logic [2:0] ST_REPORT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam int PIPE_LATENCY = 3;
  localparam int MAG_SHIFT_A  = 2;
  localparam int MAG_SHIFT_B  = 3;

endpackage

// File: rtl/cplx_magnitude_approx.sv
// Three-stage magnitude pipeline: |Re|,|Im| -> max/min sort -> max + min/4 + min/8.
// Fixed latency, one sample per cycle; i_clear drops in-flight samples, data regs hold.
module cplx_magnitude_approx
  import dsp_defs::*;
#(
  parameter int DATA_WIDTH = 18
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_clear,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_re,
  input  logic signed [DATA_WIDTH-1:0] i_im,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_valid,
  output logic                         o_busy
);

  logic [DATA_WIDTH-1:0]   w_abs_re;
  logic [DATA_WIDTH-1:0]   w_abs_im;
  logic [DATA_WIDTH-1:0]   w_sum;
  logic [DATA_WIDTH-1:0]   r_abs_a;
  logic [DATA_WIDTH-1:0]   r_abs_b;
  logic [DATA_WIDTH-1:0]   r_max;
  logic [DATA_WIDTH-1:0]   r_min;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [PIPE_LATENCY-1:0] r_vld;

  // The most negative input negates to itself, which read as unsigned is exactly 2^(W-1).
  assign w_abs_re = i_re[DATA_WIDTH-1] ? DATA_WIDTH'(-i_re) : DATA_WIDTH'(i_re);
  assign w_abs_im = i_im[DATA_WIDTH-1] ? DATA_WIDTH'(-i_im) : DATA_WIDTH'(i_im);

  // Worst case is 1.375 * 2^(W-1), so the W-bit sum cannot wrap.
  assign w_sum = r_max + (r_min >> MAG_SHIFT_A) + (r_min >> MAG_SHIFT_B);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_vld   <= '0;
      r_abs_a <= '0;
      r_abs_b <= '0;
      r_max   <= '0;
      r_min   <= '0;
      r_data  <= '0;
    end else begin
      r_vld <= i_clear ? '0 : {r_vld[PIPE_LATENCY-2:0], i_valid};
      if (i_valid) begin
        r_abs_a <= w_abs_re;
        r_abs_b <= w_abs_im;
      end
      if (r_vld[0]) begin
        r_max <= (r_abs_a > r_abs_b) ? r_abs_a : r_abs_b;
        r_min <= (r_abs_a > r_abs_b) ? r_abs_b : r_abs_a;
      end
      if (r_vld[1]) begin
        r_data <= w_sum;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_vld[PIPE_LATENCY-1];
  assign o_busy  = |r_vld[PIPE_LATENCY-2:0];

endmodule

// File: rtl/envelope_detector.sv
// Envelope of the analytic signal plus capture-wide peak/index tracking, reported once at stop.
// Latency 3 on dataOut; no back-pressure; peakValid pulses once after the pipeline drains.
module envelope_detector
  import dsp_defs::*;
#(
  parameter int DATA_WIDTH  = 18,
  parameter int INDEX_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] dataInRe,
  input  logic signed [DATA_WIDTH-1:0] dataInIm,
  input  logic                         validIn,
  input  logic                         stopDataIn,
  output logic [DATA_WIDTH-1:0]        dataOut,
  output logic                         validOut,
  output logic [DATA_WIDTH-1:0]        peakValue,
  output logic [INDEX_WIDTH-1:0]       peakIndex,
  output logic                         peakValid,
  output logic                         indexOverflow
);

  localparam logic [INDEX_WIDTH-1:0] CNT_MAX = '1;

  logic [2:0]             r_state;
  logic [INDEX_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0]  r_peak_val;
  logic [INDEX_WIDTH-1:0] r_peak_idx;
  logic                   r_peak_vld;
  logic                   r_ovf;

  logic                  w_accept;
  logic                  w_abort;
  logic                  w_start;
  logic                  w_drained;
  logic                  w_busy;
  logic [DATA_WIDTH-1:0] w_env;
  logic                  w_env_vld;

  assign w_accept  = (r_state == ST_RUN) && enable && validIn;
  assign w_abort   = !enable && ((r_state == ST_RUN) || (r_state == ST_FLUSH));
  assign w_start   = (r_state == ST_IDLE) && enable;
  // The last sample's peak update lands on the same edge that enters REPORT.
  assign w_drained = (r_state == ST_FLUSH) && enable && !w_busy;

  cplx_magnitude_approx #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mag (
    .i_clock (clock),
    .i_reset (reset),
    .i_clear (w_abort),
    .i_valid (w_accept),
    .i_re    (dataInRe),
    .i_im    (dataInIm),
    .o_data  (w_env),
    .o_valid (w_env_vld),
    .o_busy  (w_busy)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (enable) r_state <= ST_RUN;
        ST_RUN:    if (!enable) r_state <= ST_IDLE;
                   else if (stopDataIn) r_state <= ST_FLUSH;
        ST_FLUSH:  if (!enable) r_state <= ST_IDLE;
                   else if (!w_busy) r_state <= ST_REPORT;
        ST_REPORT: r_state <= ST_DONE;
        ST_DONE:   if (!enable) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || w_abort || w_start) begin
      r_count    <= '0;
      r_peak_val <= '0;
      r_peak_idx <= '0;
      r_ovf      <= 1'b0;
    end else if (w_env_vld) begin
      // Strict compare keeps the first of equal peaks.
      if (w_env > r_peak_val) begin
        r_peak_val <= w_env;
        r_peak_idx <= r_count;
      end
      if (r_count == CNT_MAX) begin
        r_ovf <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_peak_vld <= 1'b0;
    end else begin
      r_peak_vld <= w_drained;
    end
  end

  assign dataOut       = w_env;
  assign validOut      = w_env_vld;
  assign peakValue     = r_peak_val;
  assign peakIndex     = r_peak_idx;
  assign peakValid     = r_peak_vld;
  assign indexOverflow = r_ovf;

endmodule

// File: tb/tb_envelope_detector.sv
// Bench for envelope_detector: directed captures plus randomized ones, checked every
// cycle against a transaction-level model (queued envelopes, peak recomputed per capture).
module tb_envelope_detector;

  localparam int DW      = 18;
  localparam int IW      = 4;
  localparam int IDX_MAX = (1 << IW) - 1;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_FLUSH  = 2;
  localparam int M_REPORT = 3;
  localparam int M_DONE   = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic validIn = 1'b0;
  logic stopDataIn = 1'b0;
  logic signed [DW-1:0] dataInRe = '0;
  logic signed [DW-1:0] dataInIm = '0;
  logic [DW-1:0] dataOut;
  logic [DW-1:0] peakValue;
  logic [IW-1:0] peakIndex;
  logic validOut;
  logic peakValid;
  logic indexOverflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  envelope_detector #(
    .DATA_WIDTH (DW),
    .INDEX_WIDTH(IW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .dataInRe     (dataInRe),
    .dataInIm     (dataInIm),
    .validIn      (validIn),
    .stopDataIn   (stopDataIn),
    .dataOut      (dataOut),
    .validOut     (validOut),
    .peakValue    (peakValue),
    .peakIndex    (peakIndex),
    .peakValid    (peakValid),
    .indexOverflow(indexOverflow)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode = M_IDLE;
  int cyc = 0;
  int exp_q[$];
  int due_q[$];
  int cap[$];
  int last_acc = -100;
  int report_cyc = 0;
  int m_pk_val = 0;
  int m_pk_idx = 0;
  int m_ovf = 0;

  function automatic int envelope(input int re, input int im);
    int a, b, mx, mn;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return mx + mn / 4 + mn / 8;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    due_q.delete();
    cap.delete();
    m_pk_val = 0;
    m_pk_idx = 0;
    m_ovf    = 0;
  endtask

  task automatic model_peak();
    m_pk_val = 0;
    m_pk_idx = 0;
    foreach (cap[i]) begin
      if (cap[i] > m_pk_val) begin
        m_pk_val = cap[i];
        m_pk_idx = (i > IDX_MAX) ? IDX_MAX : i;
      end
    end
    m_ovf = (cap.size() > IDX_MAX) ? 1 : 0;
  endtask

  always @(negedge clock) begin
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check_eq("validOut", validOut, 1);
      check_eq("dataOut", dataOut, exp_q[0]);
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end else begin
      check_eq("validOut_idle", validOut, 0);
    end
    check_eq("peakValid", peakValid, (m_mode == M_REPORT) ? 1 : 0);
    if (m_mode == M_IDLE || m_mode == M_REPORT || m_mode == M_DONE) begin
      check_eq("peakValue", peakValue, m_pk_val);
      check_eq("peakIndex", peakIndex, m_pk_idx);
      check_eq("indexOverflow", indexOverflow, m_ovf);
    end

    if (reset) begin
      model_clear();
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (enable) begin
          model_clear();
          last_acc = -100;
          m_mode = M_RUN;
        end
        M_RUN: if (!enable) begin
          model_clear();
          m_mode = M_IDLE;
        end else begin
          if (validIn) begin
            exp_q.push_back(envelope(int'(dataInRe), int'(dataInIm)));
            due_q.push_back(cyc + 3);
            cap.push_back(exp_q[$]);
            last_acc = cyc;
          end
          if (stopDataIn) begin
            report_cyc = (cyc + 2 > last_acc + 4) ? cyc + 2 : last_acc + 4;
            m_mode = M_FLUSH;
          end
        end
        M_FLUSH: if (!enable) begin
          model_clear();
          m_mode = M_IDLE;
        end else if (cyc + 1 >= report_cyc) begin
          model_peak();
          m_mode = M_REPORT;
        end
        M_REPORT: m_mode = M_DONE;
        M_DONE:   if (!enable) m_mode = M_IDLE;
        default:  m_mode = M_IDLE;
      endcase
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic en, input logic vld, input logic stp, input int re, input int im);
    enable     = en;
    validIn    = vld;
    stopDataIn = stp;
    dataInRe   = DW'(re);
    dataInIm   = DW'(im);
    @(posedge clock);
    #1;
  endtask

  task automatic begin_cap(input logic vld);
    step(1'b1, vld, 1'b0, 123, -45);
  endtask

  task automatic sample(input int re, input int im, input logic stp);
    step(1'b1, 1'b1, stp, re, im);
  endtask

  task automatic finish_cap(input logic vld);
    repeat (7) step(1'b1, vld, 1'b0, 999, 999);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    @(negedge clock);
    check_eq({tag, "_dataOut"}, dataOut, 0);
    check_eq({tag, "_validOut"}, validOut, 0);
    check_eq({tag, "_peakValue"}, peakValue, 0);
    check_eq({tag, "_peakIndex"}, peakIndex, 0);
    check_eq({tag, "_peakValid"}, peakValid, 0);
    check_eq({tag, "_indexOverflow"}, indexOverflow, 0);
    @(posedge clock);
    #1;
  endtask

  function automatic int rand_val();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return -131072;
    if (r == 1) return 131071;
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  int ramp[5] = '{0, 5, 9, 9, 2};

  initial begin
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 0, 0);
    check_zero("reset");
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 0, 0);

    // Basic magnitudes and latency
    begin_cap(1'b0);
    sample(3, 4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    sample(-1000, 800, 1'b1);
    finish_cap(1'b0);
    check_eq("t1_peak", peakValue, 1300);

    // Extremes, no wrap
    begin_cap(1'b0);
    sample(-131072, -131072, 1'b0);
    sample(131071, 0, 1'b1);
    finish_cap(1'b0);
    check_eq("t2_peak", peakValue, 180224);
    check_eq("t2_idx", peakIndex, 0);

    // Stream with tie on the peak
    begin_cap(1'b0);
    for (int i = 0; i < 5; i++) sample(ramp[i], 0, (i == 4));
    finish_cap(1'b0);
    check_eq("t3_peak", peakValue, 9);
    check_eq("t3_idx", peakIndex, 2);

    // Abort in FLUSH, then restart
    begin_cap(1'b0);
    sample(10, 0, 1'b0);
    sample(20, 0, 1'b0);
    sample(30, 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 0, 0);
    check_eq("t4_abort_peak", peakValue, 0);
    begin_cap(1'b0);
    sample(7, 0, 1'b0);
    sample(3, 0, 1'b1);
    finish_cap(1'b0);
    check_eq("t4_restart_idx", peakIndex, 0);
    check_eq("t4_restart_peak", peakValue, 7);

    // Gapped input, validIn ignored in IDLE and DONE
    step(1'b0, 1'b1, 1'b0, 500, 500);
    begin_cap(1'b1);
    for (int i = 0; i < 6; i++) begin
      sample(100 * (i % 3) + 10 * i, -20, (i == 5));
      if (i != 5) begin
        step(1'b1, 1'b0, 1'b0, 777, 777);
        step(1'b1, 1'b0, 1'b0, 777, 777);
      end
    end
    finish_cap(1'b1);
    check_eq("t5_idx", peakIndex, 5);

    // Index saturation
    begin_cap(1'b0);
    for (int i = 0; i < 20; i++) sample(100 * i + 50, 0, (i == 19));
    finish_cap(1'b0);
    check_eq("t6_idx", peakIndex, 15);
    check_eq("t6_ovf", indexOverflow, 1);
    check_eq("t6_peak", peakValue, 1950);

    // Reset mid-stream
    begin_cap(1'b0);
    for (int i = 0; i < 5; i++) sample(1000 + i, 0, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 0, 0);
    check_zero("t6_midreset");
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 0, 0);

    // Randomized captures, some aborted
    for (int c = 0; c < 40; c++) begin
      int n;
      int abort_at;
      n = int'($urandom_range(1, 22));
      abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      begin_cap(1'($urandom_range(0, 1)));
      for (int k = 0; k < n; k++) begin
        if (k == abort_at) break;
        repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 1'($urandom_range(0, 1) & 0), rand_val(), rand_val());
        sample(rand_val(), rand_val(), (k == n - 1));
      end
      if (abort_at >= 0) begin
        step(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 0, 0);
      end else if ($urandom_range(0, 4) == 0) begin
        step(1'b0, 1'b1, 1'b0, rand_val(), rand_val());
        repeat (4) step(1'b0, 1'b0, 1'b0, 0, 0);
      end else begin
        finish_cap(1'($urandom_range(0, 1)));
      end
    end

    repeat (3) step(1'b0, 1'b0, 1'b0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
